uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one single-byte uart_tx serializer (NBYTES=1) among NREQ byte producers. The block generates the baud-rate tick and the single-cycle tx_start pulse, and holds tx_data stable for the whole frame. It sequences one complete frame per grant, using tx_busy to detect frame completion. It sits between user logic (sensor readout, status reporters) and the serializer.

Parameters:
NREQ, 4, number of requesters (2..8).
BAUD_DIV, 10417, system clocks per baud tick (100 MHz / 9600, rounded).
WDOG_TICKS, 3, baud ticks allowed for tx_busy to rise before the frame is aborted.

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  synchronous reset, active-low
req_valid  in  NREQ  requester i has a byte pending
req_data  in  NREQ*8  byte of requester i at bits [8i+7:8i]
req_ready  out  NREQ  one-cycle accept pulse; the byte is latched on this cycle
tx_start  out  1  one-cycle pulse to the serializer
tx_en  out  1  baud tick, one-cycle pulse every BAUD_DIV clocks
tx_data  out  8  latched byte, stable from accept until return to IDLE
tx_busy  in  1  serializer busy flag
grant_id  out  clog2(NREQ)  index of the current or last granted requester
ctrl_busy  out  1  high in every state except IDLE
tx_err  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; tx_data=0; rr_ptr=0; divider=0. A reset mid-frame abandons the frame immediately. The serializer finishes on its own; ticks stop until the divider restarts.
- Baud divider: counts 0..BAUD_DIV-1 and wraps to 0. tx_en=1 when count==BAUD_DIV-1. It is forced to 0 in the START cycle, so the first tick of a frame occurs exactly BAUD_DIV cycles after tx_start.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, select the winner by round-robin. Search from rr_ptr upward, modulo NREQ; the first set bit wins.
  - In the same cycle: req_ready[w]=1, tx_data<=req_data[w], grant_id<=w, go to START.
  - No request: remain in IDLE. Latency from req_valid to req_ready is 0 cycles when IDLE.
- START: tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for tx_busy=1, then go to WAIT_DONE.
  - Count tx_en pulses. If WDOG_TICKS pulses occur without tx_busy, pulse tx_err and go to IDLE.
- WAIT_DONE:
  - On tx_busy=0, go to IDLE and set rr_ptr<=(grant_id+1) mod NREQ.
  - The next grant occurs one cycle later at the earliest. Frames are back-to-back with no extra idle bit beyond the serializer's stop-bit handling.
- Handshake: a requester holds req_valid and req_data until it sees req_ready. Deasserting req_valid before the grant is legal; the request is dropped with no effect.
- A requester that keeps req_valid high is re-granted only after all other asserted requesters have been served once (fairness bound: NREQ-1 frames).
- Simultaneous release and new request: when WAIT_DONE exits, arbitration happens in the following IDLE cycle using the updated rr_ptr.
- tx_start never asserts while ctrl_busy was already high from a previous frame.

Optional Feature:
UART_ARB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest index wins; rr_ptr is not implemented.
- Undefined: round-robin as described under Behaviour.

Decomposition:
Package uart_arb_pkg contains:
- the FSM state enum
- the default BAUD_DIV constant
- a function computing the grant-index width from NREQ.

One sub-module is natural: uart_baud_gen. It holds the divider, has a synchronous clear input, and drives tx_en. The arbiter instantiates it and also drives the serializer directly.

Test Plan:
- BAUD_DIV=4, NREQ=4, a uart_tx model attached, req_valid=0001, data 0x55 -> req_ready[0] pulses in the same cycle. tx_start follows 1 cycle later. TxD shows 0,1,0,1,0,1,0,1,0,1 at 4-clock bit intervals. ctrl_busy falls after tx_busy falls.
- req_valid=1111 held, data 0xA0..0xA3 -> grant order 0,1,2,3,0. Each frame is complete before the next tx_start. No tx_start occurs while tx_busy=1.
- Fixed-priority build (UART_ARB_FIXED_PRIO_EN defined), req_valid=1010 held -> requester 1 is granted every frame and requester 3 is never granted.
- tx_busy tied to 0, BAUD_DIV=4 -> tx_err pulses 12 cycles after the first tx_en count starts (3 ticks). The block returns to IDLE and re-grants.
- rst_n=0 held for 1 cycle in the middle of WAIT_DONE -> the next cycle shows ctrl_busy=0, tx_en=0, tx_data=0x00, rr_ptr=0. A pending req_valid=0100 is granted in the next IDLE cycle.
- req_valid[2] pulsed high for 1 cycle while the block is in WAIT_DONE -> no req_ready[2], and no frame for requester 2.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and constants for the UART transmit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // 100 MHz system clock divided down to 9600 baud
    localparam int c_BAUD_DIV_DEFAULT = 10417;

    function automatic int grant_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Requester and serializer signals of the UART transmit arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int c_GW = grant_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [c_GW-1:0]   grant_id;
    logic              ctrl_busy;
    logic              tx_err;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_en, tx_data, grant_id, ctrl_busy, tx_err
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_en, tx_data, grant_id, ctrl_busy, tx_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running baud divider with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_arb_pkg::*;
#(
    parameter int BAUD_DIV = c_BAUD_DIV_DEFAULT
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_clr,
    output logic o_tick
);

    localparam int                 c_CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BAUD_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Masking during clear aligns the first tick of a frame to BAUD_DIV cycles
    assign o_tick = (r_cnt == c_LAST) && !i_clr;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin sharing of one byte serializer among NREQ
//                producers; UART_ARB_FIXED_PRIO_EN selects fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int BAUD_DIV   = c_BAUD_DIV_DEFAULT,
    parameter int WDOG_TICKS = 3
) (
    input  wire               clk,
    input  wire               rst_n,
    uart_tx_arbiter_if.master bus
);

    localparam int              c_GW        = grant_width(NREQ);
    localparam int              c_WW        = $clog2(WDOG_TICKS + 1);
    localparam logic [c_GW:0]   c_NREQ_W    = (c_GW + 1)'(NREQ);
    localparam logic [c_GW-1:0] c_LAST_ID   = c_GW'(NREQ - 1);
    localparam logic [c_WW-1:0] c_WDOG_LAST = c_WW'(WDOG_TICKS - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [c_GW-1:0]   r_grant_id;
    logic [7:0]        r_tx_data;
    logic [c_WW-1:0]   r_wdog_cnt;
    logic [c_GW-1:0]   w_base;
    logic [c_GW-1:0]   w_winner;
    logic [c_GW:0]     w_sum;
    logic              w_found;
    logic              w_accept;
    logic              w_tick;
    logic              w_clr;
    logic [2*NREQ-1:0] w_rot;
    logic [7:0]        w_bytes [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_bytes
        assign w_bytes[gi] = bus.req_data[8*gi +: 8];
    end

`ifdef UART_ARB_FIXED_PRIO_EN
    assign w_base = '0;
`else
    logic [c_GW-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_WAIT_DONE && !bus.tx_busy) begin
            r_rr_ptr <= (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + c_GW'(1);
        end
    end

    assign w_base = r_rr_ptr;
`endif

    // Rotating the request vector by the search base makes bit 0 the highest priority
    assign w_rot = {bus.req_valid, bus.req_valid} >> w_base;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, w_base} + (c_GW + 1)'(j);
                if (w_sum >= c_NREQ_W) begin
                    w_sum = w_sum - c_NREQ_W;
                end
                w_winner = w_sum[c_GW-1:0];
            end
        end
    end

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_clr        = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                bus.tx_start = 1'b1;
                w_clr        = 1'b1;
                w_state_nxt  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_tick && r_wdog_cnt == c_WDOG_LAST) begin
                    bus.tx_err  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_accept) begin
            bus.req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_wdog_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_grant_id <= w_winner;
                r_tx_data  <= w_bytes[w_winner];
            end
            if (r_state == ST_START) begin
                r_wdog_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY && w_tick) begin
                r_wdog_cnt <= r_wdog_cnt + c_WW'(1);
            end
        end
    end

    assign bus.tx_en     = w_tick;
    assign bus.tx_data   = r_tx_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.ctrl_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Randomized scoreboard bench for uart_tx_arbiter with a
//                behavioural serializer and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N  = 4;
    localparam int BD = 4;
    localparam int WD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_arbiter_if #(.NREQ(N)) bus ();

    uart_tx_arbiter #(
        .NREQ       (N),
        .BAUD_DIV   (BD),
        .WDOG_TICKS (WD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- serializer model (start, 8 data LSB first, stop) ------
    logic       ser_busy = 1'b0;
    logic       ser_done = 1'b0;
    logic [9:0] ser_sh   = '1;
    logic [9:0] ser_bits = '0;
    int         ser_cnt  = 0;
    bit         dead_ser = 1'b0;

    always @(posedge clk) begin
        ser_done <= 1'b0;
        if (!rst_n) begin
            ser_busy <= 1'b0;
            ser_cnt  <= 0;
            ser_sh   <= '1;
        end else if (!ser_busy) begin
            if (bus.tx_start && !dead_ser) begin
                ser_busy <= 1'b1;
                ser_sh   <= {1'b1, bus.tx_data, 1'b0};
                ser_cnt  <= 0;
            end
        end else if (bus.tx_en) begin
            ser_bits[ser_cnt] <= ser_sh[0];
            ser_sh            <= {1'b1, ser_sh[9:1]};
            ser_cnt           <= ser_cnt + 1;
            if (ser_cnt == 9) begin
                ser_busy <= 1'b0;
                ser_done <= 1'b1;
            end
        end
    end

    // ---------------- requester drive ----------------
    logic [N-1:0]   rv  = '0;
    logic [8*N-1:0] rd  = '0;
    logic [N-1:0]   acc = '0;
    bit             hold = 1'b0;

    assign bus.req_valid = rv;
    assign bus.req_data  = rd;
    assign bus.tx_busy   = ser_busy;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   gseq[$];
    int   err_cnt = 0;
    int   r2_cnt  = 0;
    int   cycle   = 0;
    bit   m_free  = 1'b1;
    int   m_ptr   = 0;
    int   m_gid   = 0;
    int   m_gcyc  = 0;
    logic [7:0] m_data = '0;
    bit   m_dead = 1'b0;
    bit   m_seen = 1'b0;
    bit   m_post_rst = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int           w;
        int           rel;
        logic [N-1:0] exp_rdy;
        cycle++;
        if (!rst_n) begin
            m_free     = 1'b1;
            m_ptr      = 0;
            m_post_rst = 1'b1;
            sb.delete();
        end else begin
            if (m_post_rst) begin
                chk("reset_tx_en", bus.tx_en, 0);
                chk("reset_tx_data", bus.tx_data, 0);
                chk("reset_grant_id", bus.grant_id, 0);
                m_post_rst = 1'b0;
            end
            w       = pick(rv, m_ptr);
            exp_rdy = '0;
            if (m_free && w >= 0) exp_rdy[w] = 1'b1;
            rel = cycle - m_gcyc;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("ctrl_busy", bus.ctrl_busy, !m_free);
            chk("tx_start", bus.tx_start, !m_free && rel == 1);
            chk("tx_err", bus.tx_err, !m_free && m_dead && rel == 1 + WD*BD);
            if (!m_free) begin
                chk("tx_en", bus.tx_en, rel > 1 && ((rel - 1) % BD) == 0);
                chk("grant_id", bus.grant_id, m_gid);
                chk("tx_data", bus.tx_data, m_data);
            end
            if (bus.tx_start) chk("start_while_busy", ser_busy, 0);
            if (bus.tx_err) err_cnt++;
            if (bus.req_ready[2]) r2_cnt++;
            for (int k = 0; k < N; k++) begin
                if (bus.req_ready[k]) gseq.push_back(k);
            end
            if (m_free) begin
                if (w >= 0) begin
                    m_free = 1'b0;
                    m_gid  = w;
                    m_gcyc = cycle;
                    m_data = rd[8*w +: 8];
                    m_dead = dead_ser;
                    m_seen = 1'b0;
                    if (!dead_ser) sb.push_back('{w, rd[8*w +: 8]});
                end
            end else if (rel >= 1) begin
                if (m_dead) begin
                    if (rel == 1 + WD*BD) m_free = 1'b1;
                end else if (ser_busy) begin
                    m_seen = 1'b1;
                end else if (m_seen) begin
                    m_free = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
                    m_ptr = (m_gid + 1) % N;
`endif
                end
            end
        end
    end

    // Frame monitor: compares what went out on the line with the accepted byte
    always @(negedge clk) begin
        exp_t e;
        if (ser_done && rst_n) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got frame %0h expected none (t=%0t)", ser_bits, $time);
            end else begin
                e = sb.pop_front();
                chk("start_bit", ser_bits[0], 0);
                chk("stop_bit", ser_bits[9], 1);
                chk("frame_data", ser_bits[8:1], e.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        acc = bus.req_ready;
        @(posedge clk);
        #1;
        if (!hold) rv = rv & ~acc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.ctrl_busy || rv != 0 || ser_busy) && n < 600) begin
            step();
            n++;
        end
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL timeout_%s: got busy after %0d cycles expected idle", tag, n);
        end
    endtask

    task automatic wait_ser(input string tag);
        int n = 0;
        while (!ser_busy && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL timeout_%s: got no frame start expected tx_busy", tag);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int exp_order[5];
        logic [N-1:0] hold_vec;
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_order = '{1, 1, 1, 1, 1};
        hold_vec  = 4'b1010;
`else
        exp_order = '{0, 1, 2, 3, 0};
        hold_vec  = 4'b1111;
`endif
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // single frame of 0x55 from requester 0
        rd[7:0] = 8'h55;
        rv      = 4'b0001;
        wait_idle("single");

        // all requesters held: grant rotation after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        gseq.delete();
        rd   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        hold = 1'b1;
        rv   = hold_vec;
        n    = 0;
        while (gseq.size() < 5 && n < 1000) begin
            step();
            n++;
        end
        hold = 1'b0;
        rv   = '0;
        wait_idle("rotation");
        chk("grant_count", gseq.size(), 5);
        for (int k = 0; k < 5 && k < gseq.size(); k++) chk("grant_order", gseq[k], exp_order[k]);

        // randomized traffic with occasional withdrawn requests
        repeat (2500) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 11) == 0) begin
                        rv[i]        = 1'b1;
                        rd[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    rv[i] = 1'b0;
                end
            end
        end
        rv = '0;
        wait_idle("random");

        // one-cycle request pulse during a frame is dropped
        rd[7:0] = 8'h3C;
        rv      = 4'b0001;
        wait_ser("pulse");
        step();
        r2_cnt     = 0;
        rd[23:16]  = 8'h99;
        rv[2]      = 1'b1;
        step();
        rv[2] = 1'b0;
        wait_idle("pulse");
        chk("pulse_no_grant", r2_cnt, 0);

        // dead serializer: watchdog aborts and the block re-grants
        dead_ser = 1'b1;
        err_cnt  = 0;
        rd[7:0]  = 8'h81;
        rv       = 4'b0001;
        hold     = 1'b1;
        n        = 0;
        while (err_cnt < 2 && n < 200) begin
            step();
            n++;
        end
        hold = 1'b0;
        rv   = '0;
        wait_idle("wdog");
        dead_ser = 1'b0;
        chk("wdog_errs", err_cnt, 2);

        // reset in the middle of a frame with requester 2 pending
        rd[7:0] = 8'h42;
        rv      = 4'b0001;
        wait_ser("reset");
        step();
        rd[23:16] = 8'hC7;
        rv        = 4'b0100;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        wait_idle("post_reset");

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
